// File: rtl/vga_pkg.sv
// Shared VGA 640x480@60 timing defaults and small decode helpers.
package vga_pkg;

    localparam int CNT_W = 10;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    localparam int DEF_H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int DEF_V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    // Half-open interval test: lo <= v < hi.
    function automatic logic in_range(input logic [CNT_W-1:0] v,
                                      input logic [CNT_W-1:0] lo,
                                      input logic [CNT_W-1:0] hi);
        return (v >= lo) && (v < hi);
    endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel/line counters plus registered sync and blank.
// Optional macro VGA_TIMING_PIPE_EN adds one strobe-gated stage on hsync/vsync/blank_n.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_pix_en,
    output logic [CNT_W-1:0] o_x_cnt,
    output logic [CNT_W-1:0] o_y_cnt,
    output logic             o_hsync,
    output logic             o_vsync,
    output logic             o_blank_n,
    output logic             o_sync_n,
    output logic             o_line_start,
    output logic             o_frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] X_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] Y_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] X_VIS    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] Y_VIS    = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    logic [CNT_W-1:0] x_reg, x_next;
    logic [CNT_W-1:0] y_reg, y_next;
    logic             hsync_reg, hsync_next;
    logic             vsync_reg, vsync_next;
    logic             blank_n_reg, blank_n_next;
    logic             line_start_reg, frame_start_reg;

    // The >= compares make any out-of-range count fall back to 0 on the next strobe.
    always_comb begin
        x_next = x_reg;
        y_next = y_reg;
        if (i_pix_en) begin
            if (x_reg >= X_LAST) begin
                x_next = '0;
                y_next = (y_reg >= Y_LAST) ? '0 : y_reg + 1'b1;
            end else begin
                x_next = x_reg + 1'b1;
            end
        end
    end

    // Decoding the next-state counters keeps sync/blank aligned with the counters they ship with.
    always_comb begin
        hsync_next   = !in_range(x_next, HS_START, HS_END);
        vsync_next   = !in_range(y_next, VS_START, VS_END);
        blank_n_next = (x_next < X_VIS) && (y_next < Y_VIS);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            x_reg           <= '0;
            y_reg           <= '0;
            hsync_reg       <= 1'b1;
            vsync_reg       <= 1'b1;
            blank_n_reg     <= 1'b0;
            line_start_reg  <= 1'b0;
            frame_start_reg <= 1'b0;
        end else begin
            x_reg           <= x_next;
            y_reg           <= y_next;
            hsync_reg       <= hsync_next;
            vsync_reg       <= vsync_next;
            blank_n_reg     <= blank_n_next;
            line_start_reg  <= i_pix_en && (x_next == '0);
            frame_start_reg <= i_pix_en && (x_next == '0) && (y_next == '0);
        end
    end

`ifdef VGA_TIMING_PIPE_EN
    logic hsync_pipe_reg;
    logic vsync_pipe_reg;
    logic blank_n_pipe_reg;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            hsync_pipe_reg   <= 1'b1;
            vsync_pipe_reg   <= 1'b1;
            blank_n_pipe_reg <= 1'b0;
        end else if (i_pix_en) begin
            hsync_pipe_reg   <= hsync_reg;
            vsync_pipe_reg   <= vsync_reg;
            blank_n_pipe_reg <= blank_n_reg;
        end
    end

    assign o_hsync   = hsync_pipe_reg;
    assign o_vsync   = vsync_pipe_reg;
    assign o_blank_n = blank_n_pipe_reg;
`else
    assign o_hsync   = hsync_reg;
    assign o_vsync   = vsync_reg;
    assign o_blank_n = blank_n_reg;
`endif

    assign o_x_cnt       = x_reg;
    assign o_y_cnt       = y_reg;
    assign o_line_start  = line_start_reg;
    assign o_frame_start = frame_start_reg;
    assign o_sync_n      = 1'b0;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: full-size instance for horizontal timing, a shrunken one for vertical/frame timing.
module tb_vga_timing_gen;

`ifdef VGA_TIMING_PIPE_EN
    localparam int PIPE = 1;
`else
    localparam int PIPE = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pix_en = 1'b1;

    logic [9:0] x_cnt, y_cnt;
    logic       hsync, vsync, blank_n, sync_n, line_start, frame_start;

    logic [9:0] s_x_cnt, s_y_cnt;
    logic       s_hsync, s_vsync, s_blank_n, s_sync_n, s_line_start, s_frame_start;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    vga_timing_gen dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_pix_en     (pix_en),
        .o_x_cnt      (x_cnt),
        .o_y_cnt      (y_cnt),
        .o_hsync      (hsync),
        .o_vsync      (vsync),
        .o_blank_n    (blank_n),
        .o_sync_n     (sync_n),
        .o_line_start (line_start),
        .o_frame_start(frame_start)
    );

    // 15 x 8 raster: hsync low x=10..12, vsync low y=5..6, visible 8 x 4, 120 strobes per frame.
    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1)
    ) dut_s (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_pix_en     (pix_en),
        .o_x_cnt      (s_x_cnt),
        .o_y_cnt      (s_y_cnt),
        .o_hsync      (s_hsync),
        .o_vsync      (s_vsync),
        .o_blank_n    (s_blank_n),
        .o_sync_n     (s_sync_n),
        .o_line_start (s_line_start),
        .o_frame_start(s_frame_start)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    task automatic advance(input int n);
        pix_en = 1'b1;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        pix_en = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check("rst_x", 32'(x_cnt), 0);
        check("rst_y", 32'(y_cnt), 0);
        check("rst_hsync", 32'(hsync), 1);
        check("rst_vsync", 32'(vsync), 1);
        check("rst_blank_n", 32'(blank_n), 0);
        check("rst_line_start", 32'(line_start), 0);
        check("rst_frame_start", 32'(frame_start), 0);
        check("rst_s_x", 32'(s_x_cnt), 0);
        check("rst_s_frame_start", 32'(s_frame_start), 0);
        rst_n = 1'b1;
    endtask

    initial begin
        int cnt;
        bit seen;

        do_reset();
        check("sync_n", 32'(sync_n), 0);

        advance(1);
        check("first_x", 32'(x_cnt), 1);
        check("first_y", 32'(y_cnt), 0);
        check("first_frame_start", 32'(frame_start), 0);

        advance(99);
        check("x_100", 32'(x_cnt), 100);
        pix_en = 1'b0;
        for (int i = 0; i < 7; i++) begin
            @(posedge clk);
            #1;
            check("hold_x", 32'(x_cnt), 100);
            check("hold_line_start", 32'(line_start), 0);
        end
        advance(1);
        check("resume_x", 32'(x_cnt), 101);

        // Horizontal decode around blank and hsync edges.
        advance(538);
        check("x_639", 32'(x_cnt), 639);
        check("blank_639", 32'(blank_n), 1);
        advance(1);
        check("blank_640", 32'(blank_n), (PIPE == 1) ? 1 : 0);
        advance(1);
        check("blank_641", 32'(blank_n), 0);
        advance(14);
        check("x_655", 32'(x_cnt), 655);
        check("hsync_655", 32'(hsync), 1);
        advance(1);
        check("hsync_656", 32'(hsync), (PIPE == 1) ? 1 : 0);
        advance(1);
        check("hsync_657", 32'(hsync), 0);
        advance(94);
        check("hsync_751", 32'(hsync), 0);
        advance(1);
        check("x_752", 32'(x_cnt), 752);
        check("hsync_752", 32'(hsync), (PIPE == 1) ? 0 : 1);
        advance(1);
        check("hsync_753", 32'(hsync), 1);

        // Line wrap at (799,10); pulse must drop even while the strobe is idle.
        advance(8046);
        check("x_799", 32'(x_cnt), 799);
        check("y_10", 32'(y_cnt), 10);
        advance(1);
        check("wrap_x", 32'(x_cnt), 0);
        check("wrap_y", 32'(y_cnt), 11);
        check("wrap_line_start", 32'(line_start), 1);
        check("wrap_frame_start", 32'(frame_start), 0);
        pix_en = 1'b0;
        @(posedge clk);
        #1;
        check("idle_line_start", 32'(line_start), 0);
        check("idle_x", 32'(x_cnt), 0);

        // Reset mid-frame, then resume from (0,0).
        do_reset();
        advance(1);
        check("resume_rst_x", 32'(x_cnt), 1);
        check("resume_rst_y", 32'(y_cnt), 0);
        check("resume_rst_frame_start", 32'(frame_start), 0);
        check("resume_rst_s_x", 32'(s_x_cnt), 1);

        // Small raster: vertical decode and frame wrap.
        advance(51);
        check("s_x_7", 32'(s_x_cnt), 7);
        check("s_y_3", 32'(s_y_cnt), 3);
        check("s_blank_7_3", 32'(s_blank_n), 1);
        advance(1);
        check("s_blank_8_3", 32'(s_blank_n), (PIPE == 1) ? 1 : 0);
        advance(7);
        check("s_x_0", 32'(s_x_cnt), 0);
        check("s_y_4", 32'(s_y_cnt), 4);
        check("s_blank_0_4", 32'(s_blank_n), 0);
        advance(16);
        check("s_y_5", 32'(s_y_cnt), 5);
        check("s_vsync_y5", 32'(s_vsync), 0);
        advance(15);
        check("s_vsync_y6", 32'(s_vsync), 0);
        advance(15);
        check("s_y_7", 32'(s_y_cnt), 7);
        check("s_vsync_y7", 32'(s_vsync), 1);
        advance(13);
        check("s_x_14", 32'(s_x_cnt), 14);
        check("s_frame_start_pre", 32'(s_frame_start), 0);
        advance(1);
        check("s_frame_x", 32'(s_x_cnt), 0);
        check("s_frame_y", 32'(s_y_cnt), 0);
        check("s_frame_start", 32'(s_frame_start), 1);
        check("s_frame_line_start", 32'(s_line_start), 1);
        advance(1);
        check("s_frame_start_drop", 32'(s_frame_start), 0);

        cnt  = 1;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            advance(1);
            cnt++;
            if (s_frame_start) seen = 1'b1;
        end
        check("s_frame_period", 32'(cnt), 120);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
